music_sequencer: RTL and testbench
==================================

# music_sequencer

Plays a stored song by stepping a note-index ROM at tempo rate. It drives the 4-bit note index (0 = rest) into the note-to-frequency-code decoder, which feeds the tone divider. The block sits between the song ROM and the tone generator and supplies start/stop/pause/loop control plus end-of-song status.

## Interface
- ADDR_W, 8, song ROM address width
- SONG_LEN, 139, number of song entries, 1..2^ADDR_W
- TICKS_PER_NOTE, 1, TEMPO_EN pulses each entry is held, ≥1
- CLK  in  1  system clock, single clock domain, rising edge
- RST  in  1  asynchronous, active-high reset
- TEMPO_EN  in  1  one-cycle beat-tick enable from the tempo divider
- START  in  1  one-cycle pulse, begin playback from entry 0
- STOP  in  1  one-cycle pulse, abort playback
- PAUSE  in  1  level; holds position and outputs rest while high
- LOOP  in  1  level; sampled at song end, restart instead of finishing
- ROM_ADDR  out  ADDR_W  song ROM address (ROM has synchronous read, 1-cycle latency)
- ROM_DATA  in  4  note index from ROM
- INX  out  4  current note index to the frequency-code decoder
- NOTE_STB  out  1  one-cycle pulse when a new entry is loaded into INX
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse at natural end of song (not on STOP, not when looping)

## Operation
- All outputs registered. Reset values: ROM_ADDR=0, INX=0, NOTE_STB=0, BUSY=0, DONE=0, state IDLE, tick counter 0, saved note 0.
- States: IDLE, FETCH, LOAD, HOLD, PAUSED.
- IDLE: START → FETCH with ROM_ADDR=0.
- FETCH: ROM_ADDR stable for one cycle → LOAD.
- LOAD: saved note ← ROM_DATA, INX ← ROM_DATA, NOTE_STB ← 1, tick counter ← 0 → HOLD.
- HOLD: on TEMPO_EN, if tick counter < TICKS_PER_NOTE-1, increment it. Otherwise the entry ends:
  - if ROM_ADDR < SONG_LEN-1: ROM_ADDR+1, go to FETCH;
  - if ROM_ADDR = SONG_LEN-1 and LOOP=1: ROM_ADDR ← 0, go to FETCH, no DONE;
  - if ROM_ADDR = SONG_LEN-1 and LOOP=0: DONE ← 1, INX ← 0, ROM_ADDR ← 0, go to IDLE.
- HOLD with PAUSE=1 → PAUSED, INX ← 0. This takes priority over a TEMPO_EN in the same cycle; that tick is not counted.
- PAUSED: TEMPO_EN ignored; tick counter and ROM_ADDR frozen. When PAUSE falls → HOLD, INX ← saved note, no NOTE_STB.
- PAUSE asserted during FETCH/LOAD takes effect on entry to HOLD.
- STOP, any state, highest priority: next state IDLE, INX=0, ROM_ADDR=0, tick counter 0, no DONE.
- START and STOP in the same cycle: STOP wins. START while BUSY: ignored.
- TEMPO_EN during FETCH/LOAD is dropped. This is acceptable because TEMPO_EN period ≫ 3 cycles.
- Tick counter width max(1, $clog2(TICKS_PER_NOTE)). ROM_ADDR increment never exceeds SONG_LEN-1, so there is no natural wrap.
- Reset mid-playback: immediate return to reset values; no DONE.

## Timing
- START sampled at cycle n edge → FETCH in n+1 → LOAD in n+2 (ROM_DATA valid) → INX and NOTE_STB valid in n+3. Start latency is 3 cycles.
- Final TEMPO_EN of an entry at cycle m → new INX at m+3. The old note persists through m+1..m+2.
- DONE and the return to rest (INX=0) appear in the cycle after the final TEMPO_EN. BUSY falls in the same cycle.
- STOP at cycle k → BUSY=0, INX=0 at k+1.
- PAUSE rising, sampled at cycle p while in HOLD → INX=0 at p+1. PAUSE falling sampled at q → INX restored at q+1.

## Structure
- Shared package music_pkg holds:
  - state encoding localparams;
  - NOTE_W=4;
  - NOTE_REST=4'd0.
- The note-to-frequency-code decoder reuses the same NOTE_W.
- One natural sub-module is music_tick_counter. It counts TEMPO_EN, with clear, enable, and a terminal flag for TICKS_PER_NOTE. Everything else stays in the top FSM.

## Test plan
Bench configuration: SONG_LEN=4, TICKS_PER_NOTE=2, ROM = {5,6,0,7}, TEMPO_EN every 20 cycles.
- Basic playback: START → INX sequence 5,6,0,7, each held 2 ticks; NOTE_STB ×4; DONE once after the 8th tick; INX=0, BUSY=0.
- Loop: LOOP=1 → after 7, INX returns to 5 at +3 cycles; no DONE. LOOP dropped before the last tick → DONE, IDLE.
- Pause: PAUSE high mid-note 6 for 100 cycles → INX=0, ROM_ADDR=1 frozen. On release, INX=6 with no NOTE_STB; the remaining tick count is preserved (1 tick left).
- STOP/START collision: START during playback is ignored. STOP with START in the same cycle → IDLE, INX=0, no DONE. STOP during FETCH → IDLE next cycle.
- Async reset mid-note 0 → all outputs 0 immediately, without waiting for a CLK edge. A later START replays from entry 0.
- Edge parameters: TICKS_PER_NOTE=1 and SONG_LEN=1 → a single note of 1 tick, then DONE. TEMPO_EN in the LOAD cycle is dropped.

Source files
------------

// File: rtl/music_pkg.sv
// Shared types and constants for the song sequencer and the note-to-frequency decoder.
package music_pkg;

  localparam int unsigned NOTE_W  = 4;
  localparam int unsigned STATE_W = 3;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
  localparam logic [STATE_W-1:0] ST_LOAD   = 3'd2;
  localparam logic [STATE_W-1:0] ST_HOLD   = 3'd3;
  localparam logic [STATE_W-1:0] ST_PAUSED = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_LOAD   = ST_LOAD,
    S_HOLD   = ST_HOLD,
    S_PAUSED = ST_PAUSED
  } state_e;

endpackage

// File: rtl/music_tick_counter.sv
// Counts beat ticks within one song entry; terminal_c marks the last tick of the entry.
module music_tick_counter #(
  parameter int unsigned TICKS_PER_NOTE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic terminal_c
);

  localparam int unsigned CNT_W = (TICKS_PER_NOTE > 1) ? $clog2(TICKS_PER_NOTE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_NOTE - 1);

  logic [CNT_W-1:0] cnt_q;

  assign terminal_c = (cnt_q == CNT_LAST);

  // Saturates at the terminal value; the owner clears it when a new entry loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !terminal_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/music_sequencer.sv
// Steps a synchronous-read song ROM at tempo rate and drives the current note index,
// with start/stop/pause/loop control and end-of-song pulse.
module music_sequencer
  import music_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned SONG_LEN       = 139,
  parameter int unsigned TICKS_PER_NOTE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tempo_en,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_data,
  output logic [NOTE_W-1:0] inx,
  output logic              note_stb,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  state_e            state_q, state_d;
  logic [NOTE_W-1:0] saved_q, saved_d;
  logic [ADDR_W-1:0] addr_d;
  logic [NOTE_W-1:0] inx_d;
  logic              stb_d, busy_d, done_d;
  logic              cnt_clr_c, cnt_inc_c, tick_last_c;

  music_tick_counter #(
    .TICKS_PER_NOTE(TICKS_PER_NOTE)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr_c),
    .en        (cnt_inc_c),
    .terminal_c(tick_last_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      saved_q  <= NOTE_REST;
      rom_addr <= '0;
      inx      <= NOTE_REST;
      note_stb <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      rom_addr <= addr_d;
      inx      <= inx_d;
      note_stb <= stb_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next-state and next-output logic; STOP overrides everything.
  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    addr_d    = rom_addr;
    inx_d     = inx;
    stb_d     = 1'b0;
    done_d    = 1'b0;
    cnt_clr_c = 1'b0;
    cnt_inc_c = 1'b0;

    if (stop) begin
      state_d   = S_IDLE;
      inx_d     = NOTE_REST;
      addr_d    = '0;
      cnt_clr_c = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_FETCH;
            addr_d  = '0;
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          saved_d   = rom_data;
          inx_d     = rom_data;
          stb_d     = 1'b1;
          cnt_clr_c = 1'b1;
          state_d   = S_HOLD;
        end
        S_HOLD: begin
          if (pause) begin
            state_d = S_PAUSED;
            inx_d   = NOTE_REST;
          end else if (tempo_en) begin
            if (!tick_last_c) begin
              cnt_inc_c = 1'b1;
            end else if (rom_addr < LAST_ADDR) begin
              addr_d  = rom_addr + ADDR_W'(1);
              state_d = S_FETCH;
            end else if (loop) begin
              addr_d  = '0;
              state_d = S_FETCH;
            end else begin
              done_d    = 1'b1;
              inx_d     = NOTE_REST;
              addr_d    = '0;
              cnt_clr_c = 1'b1;
              state_d   = S_IDLE;
            end
          end
        end
        S_PAUSED: begin
          if (!pause) begin
            state_d = S_HOLD;
            inx_d   = saved_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Randomized and directed bench for music_sequencer against a behavioural playback model.
module tb_music_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tempo_en, start, stop, pause, loop;
  logic [7:0] rom_addr;
  logic [3:0] rom_data;
  logic [3:0] inx;
  logic       note_stb, busy, done;

  logic       e_tempo, e_start;
  logic [1:0] e_rom_addr;
  logic [3:0] e_rom_data;
  logic [3:0] e_inx;
  logic       e_stb, e_busy, e_done;

  logic [3:0] rom_mem [4];
  int         song [4] = '{5, 6, 0, 7};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_stb    = 0;
  int n_done   = 0;
  bit auto_tempo;
  int guard;

  // Model state: playback position, ticks heard, cycles until the note appears.
  bit m_busy, m_paused, m_stb, m_done;
  int m_idx, m_ticks, m_wait, m_note, m_inx, m_addr;

  always #5 clk = ~clk;

  music_sequencer #(.ADDR_W(8), .SONG_LEN(4), .TICKS_PER_NOTE(2)) u_dut (
    .clk(clk), .rst(rst), .tempo_en(tempo_en), .start(start), .stop(stop),
    .pause(pause), .loop(loop), .rom_addr(rom_addr), .rom_data(rom_data),
    .inx(inx), .note_stb(note_stb), .busy(busy), .done(done)
  );

  music_sequencer #(.ADDR_W(2), .SONG_LEN(1), .TICKS_PER_NOTE(1)) u_edge (
    .clk(clk), .rst(rst), .tempo_en(e_tempo), .start(e_start), .stop(1'b0),
    .pause(1'b0), .loop(1'b0), .rom_addr(e_rom_addr), .rom_data(e_rom_data),
    .inx(e_inx), .note_stb(e_stb), .busy(e_busy), .done(e_done)
  );

  always_ff @(posedge clk) begin
    rom_data   <= (rom_addr < 8'd4) ? rom_mem[rom_addr[1:0]] : 4'd0;
    e_rom_data <= (e_rom_addr == 2'd0) ? 4'd9 : 4'd0;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_paused = 0; m_stb = 0; m_done = 0;
    m_idx = 0; m_ticks = 0; m_wait = 0; m_note = 0; m_inx = 0; m_addr = 0;
  endtask

  // One clock edge of the song player, using the inputs present at that edge.
  task automatic model_edge();
    m_stb = 0;
    m_done = 0;
    if (rst) begin
      model_reset();
    end else if (stop) begin
      m_busy = 0; m_inx = 0; m_idx = 0; m_wait = 0; m_paused = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_idx = 0; m_wait = 2;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_note = song[m_idx]; m_inx = m_note; m_stb = 1; m_ticks = 0; m_paused = 0;
      end else begin
        m_wait = 1;
      end
    end else if (m_paused) begin
      if (!pause) begin
        m_paused = 0; m_inx = m_note;
      end
    end else if (pause) begin
      m_paused = 1; m_inx = 0;
    end else if (tempo_en) begin
      m_ticks++;
      if (m_ticks == 2) begin
        if (m_idx < 3) begin
          m_idx++; m_wait = 2;
        end else if (loop) begin
          m_idx = 0; m_wait = 2;
        end else begin
          m_busy = 0; m_done = 1; m_inx = 0; m_idx = 0;
        end
      end
    end
    m_addr = m_busy ? m_idx : 0;
  endtask

  task automatic step();
    if (auto_tempo) tempo_en = (cyc % 20 == 19);
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("inx", int'(inx), m_inx);
    check("note_stb", int'(note_stb), int'(m_stb));
    check("busy", int'(busy), int'(m_busy));
    check("done", int'(done), int'(m_done));
    check("rom_addr", int'(rom_addr), m_addr);
    if (note_stb) n_stb++;
    if (done) n_done++;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rom_mem[0] = 4'd5; rom_mem[1] = 4'd6; rom_mem[2] = 4'd0; rom_mem[3] = 4'd7;
    rst = 1'b1;
    tempo_en = 0; start = 0; stop = 0; pause = 0; loop = 0;
    e_tempo = 0; e_start = 0;
    auto_tempo = 1;
    model_reset();
    #3;
    check("reset_inx", int'(inx), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_addr", int'(rom_addr), 0);
    run(2);
    rst = 1'b0;

    // Basic playback
    n_stb = 0; n_done = 0;
    start = 1'b1;
    run(200);
    check("basic_stb_count", n_stb, 4);
    check("basic_done_count", n_done, 1);

    // Loop, then release loop before the end
    n_done = 0;
    loop = 1'b1; start = 1'b1;
    run(200);
    check("loop_no_done", n_done, 0);
    loop = 1'b0;
    guard = 0;
    while (n_done == 0 && guard < 300) begin step(); guard++; end
    check("loop_release_done", n_done, 1);
    run(5);

    // Pause mid-note 6 with one tick remaining
    start = 1'b1;
    guard = 0;
    while (!(m_busy && m_idx == 1 && m_wait == 0 && m_ticks == 1) && guard < 400) begin
      step(); guard++;
    end
    check("reach_note6", int'(guard < 400), 1);
    run(3);
    pause = 1'b1;
    run(100);
    check("pause_inx", int'(inx), 0);
    check("pause_addr", int'(rom_addr), 1);
    pause = 1'b0;
    n_stb = 0;
    step();
    check("resume_inx", int'(inx), 6);
    check("resume_no_stb", n_stb, 0);
    run(200);

    // START while busy ignored; STOP+START collision; STOP during FETCH
    n_done = 0;
    start = 1'b1; step(); run(30);
    start = 1'b1; step();
    stop = 1'b1; start = 1'b1; step();
    check("collide_busy", int'(busy), 0);
    check("collide_inx", int'(inx), 0);
    start = 1'b1; step();
    stop = 1'b1; step();
    check("stop_fetch_busy", int'(busy), 0);
    check("stop_no_done", n_done, 0);
    run(5);

    // Asynchronous reset during the rest entry
    start = 1'b1;
    guard = 0;
    while (!(m_busy && m_idx == 2 && m_wait == 0) && guard < 400) begin step(); guard++; end
    check("reach_rest", int'(guard < 400), 1);
    run(3);
    #2 rst = 1'b1;
    #1;
    check("async_busy", int'(busy), 0);
    check("async_addr", int'(rom_addr), 0);
    check("async_inx", int'(inx), 0);
    step();
    rst = 1'b0;
    start = 1'b1;
    run(5);
    check("replay_inx", int'(inx), 5);

    // Single-entry, single-tick configuration; tick in LOAD is dropped
    e_start = 1'b1; step(); e_start = 1'b0;
    check("edge_busy", int'(e_busy), 1);
    step();
    check("edge_load_inx", int'(e_inx), 0);
    e_tempo = 1'b1; step(); e_tempo = 1'b0;
    check("edge_inx", int'(e_inx), 9);
    check("edge_stb", int'(e_stb), 1);
    step();
    check("edge_hold_busy", int'(e_busy), 1);
    check("edge_hold_done", int'(e_done), 0);
    e_tempo = 1'b1; step(); e_tempo = 1'b0;
    check("edge_done", int'(e_done), 1);
    check("edge_end_inx", int'(e_inx), 0);
    check("edge_end_busy", int'(e_busy), 0);
    step();
    check("edge_done_pulse", int'(e_done), 0);

    // Random control traffic
    auto_tempo = 0;
    for (int i = 0; i < 3000; i++) begin
      tempo_en = ($urandom_range(0, 11) == 0);
      start    = ($urandom_range(0, 29) == 0);
      stop     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) pause = ~pause;
      if ($urandom_range(0, 99) == 0) loop = ~loop;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
